decimal_input_unit: RTL

- User-input counterpart of the seven-segment output stage.
- Collects a decimal number typed on board switches and push-buttons, converts it digit-by-digit to a 32-bit unsigned binary value, and hands it to the processor on request.
- Provides a live binary value so the output stage can echo the number while it is being typed.
- Sits between the board I/O pins and the processor's input instruction path.

---
 rtl/decimal_input_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/decimal_input_unit.sv
// decimal_input_unit: debounced switch/button decimal entry.
// Accumulates BCD digits into a 32-bit binary value and hands it to the
// processor on request.
module decimal_input_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  sw_digit,
    input  logic        key_digit_n,
    input  logic        key_enter_n,
    input  logic        key_clear_n,
    output logic [31:0] data,
    output logic        valid,
    output logic [31:0] live,
    output logic [3:0]  ndigits,
    output logic        collecting
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      MAXD     = 4'(MAX_DIGITS);

    localparam int unsigned K_DIGIT = 0;
    localparam int unsigned K_ENTER = 1;
    localparam int unsigned K_CLEAR = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    logic [2:0]    w_pin;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db;
    logic [2:0]    r_db_q;
    logic [2:0]    r_ev;
    logic [CW-1:0] r_cnt [3];

    state_t        r_state;
    logic [31:0]   r_data;
    logic [31:0]   r_live;
    logic [3:0]    r_ndigits;
    logic          r_valid;
    logic          r_collecting;

    logic [31:0]   w_next_live;
    logic          w_digit_ok;

    assign w_pin = {key_clear_n, key_enter_n, key_digit_n};

    // Synchronize, debounce and turn each debounced 1->0 flip into a one-cycle press pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            r_db_q  <= '1;
            r_ev    <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_ev    <= r_db_q & ~r_db;
            for (int unsigned k = 0; k < 3; k++) begin
                if (r_sync2[k] != r_db[k]) begin
                    if (r_cnt[k] == CNT_LAST) begin
                        r_db[k]  <= r_sync2[k];
                        r_cnt[k] <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    // live*10 + digit using shifts only
    assign w_next_live = {r_live[28:0], 3'b000} + {r_live[30:0], 1'b0} + {28'd0, sw_digit};
    assign w_digit_ok  = (sw_digit <= 4'd9) && (r_ndigits < MAXD);

    // Entry FSM: abort on req drop, then clear > enter > digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_live       <= '0;
            r_ndigits    <= '0;
            r_valid      <= 1'b0;
            r_collecting <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_live       <= '0;
                        r_ndigits    <= '0;
                        r_collecting <= 1'b1;
                        r_state      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (!req) begin
                        r_collecting <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (r_ev[K_CLEAR]) begin
                        r_live    <= '0;
                        r_ndigits <= '0;
                    end else if (r_ev[K_ENTER]) begin
                        r_data       <= r_live;
                        r_valid      <= 1'b1;
                        r_collecting <= 1'b0;
                        r_state      <= S_DONE;
                    end else if (r_ev[K_DIGIT] && w_digit_ok) begin
                        r_live    <= w_next_live;
                        r_ndigits <= r_ndigits + 4'd1;
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_valid      <= 1'b0;
                    r_collecting <= 1'b0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign live       = r_live;
    assign ndigits    = r_ndigits;
    assign collecting = r_collecting;

endmodule
